vga_bus_writer: RTL and testbench

Bus-side initiator for the VGA framebuffer write port. Accepts single-pixel write requests over a valid/ready handshake and drives the asynchronous SRAM-style processor bus (`ncs`, `nwe`, `nwe1`, `addr_pr`, `sram_data`) with the two-phase address scheme the framebuffer side decodes. Phase 1 carries pixel address bits [9:0]; phase 2 carries bits [13:10] and commits the write. It replaces the external processor in FPGA-only builds and in the framebuffer bench.

---
 rtl/vga_bus_writer_if.sv | 48 ++++
 rtl/vga_bus_writer.sv | 180 ++++++++++++++++++
 tb/tb_vga_bus_writer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_bus_writer_if.sv
// Request handshake plus asynchronous SRAM-style processor bus for the
// framebuffer write port. The "master" side issues pixel write requests and
// observes the bus; the "slave" side (vga_bus_writer) accepts the requests and
// drives the bus pins.
interface vga_bus_writer_if;
  // Request side
  logic        req_valid;
  logic [13:0] req_addr;
  logic        req_data;
  logic        req_ready;
  logic        busy;
  logic        done;

  // Processor bus side
  logic        ncs;
  logic        nwe;
  logic        nwe1;
  logic [12:0] addr_pr;
  logic [7:0]  sram_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  busy,
    input  done,
    input  ncs,
    input  nwe,
    input  nwe1,
    input  addr_pr,
    input  sram_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output busy,
    output done,
    output ncs,
    output nwe,
    output nwe1,
    output addr_pr,
    output sram_data
  );
endinterface

// File: rtl/vga_bus_writer.sv
// Bus-side initiator for the VGA framebuffer write port.
// One accepted pixel write becomes two bus phases: the first carries pixel
// address bits [9:0], the second carries bits [13:10] (with addr_pr[10] set
// as the phase marker) and commits the pixel on the framebuffer side. Every
// phase is SETUP / STROBE / HOLD cycles with ncs low, followed by GAP cycles
// with ncs high. All bus and handshake outputs come straight from flops.
module vga_bus_writer #(
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1,
  parameter int GAP    = 1
) (
  input logic            clk,
  input logic            rst,
  vga_bus_writer_if.slave bus
);

  // Cycle counts narrowed to the 4-bit phase counter width.
  localparam logic [3:0] SETUP_LEN  = 4'(SETUP);
  localparam logic [3:0] STROBE_LEN = 4'(STROBE);
  localparam logic [3:0] HOLD_LEN   = 4'(HOLD);
  localparam logic [3:0] GAP_LEN    = 4'(GAP);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LO_SETUP  = 4'd1,
    LO_STROBE = 4'd2,
    LO_HOLD   = 4'd3,
    LO_GAP    = 4'd4,
    HI_SETUP  = 4'd5,
    HI_STROBE = 4'd6,
    HI_HOLD   = 4'd7,
    HI_GAP    = 4'd8
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  hi_nib_reg, hi_nib_next;

  logic        ncs_reg, ncs_next;
  logic        nwe_reg, nwe_next;
  logic [12:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        ready_reg, ready_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic        accept;
  logic        last_cycle;

  // A request is taken only while the registered ready is high (IDLE).
  assign accept     = bus.req_valid & ready_reg;
  // The counter holds the remaining cycles of the current timed state.
  assign last_cycle = (cnt_reg == 4'd1);

  // Duration of each timed state; IDLE is untimed and parks the counter at 0.
  function automatic logic [3:0] state_len(input state_t s);
    logic [3:0] len;
    case (s)
      LO_SETUP, HI_SETUP:   len = SETUP_LEN;
      LO_STROBE, HI_STROBE: len = STROBE_LEN;
      LO_HOLD, HI_HOLD:     len = HOLD_LEN;
      LO_GAP, HI_GAP:       len = GAP_LEN;
      default:              len = 4'd0;
    endcase
    return len;
  endfunction

  // State register, phase counter and captured upper address nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      hi_nib_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_nib_reg <= hi_nib_next;
    end
  end

  // Next-state logic: walk the eight timed states, advancing on the last cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (accept)     state_next = LO_SETUP;
      LO_SETUP:  if (last_cycle) state_next = LO_STROBE;
      LO_STROBE: if (last_cycle) state_next = LO_HOLD;
      LO_HOLD:   if (last_cycle) state_next = LO_GAP;
      LO_GAP:    if (last_cycle) state_next = HI_SETUP;
      HI_SETUP:  if (last_cycle) state_next = HI_STROBE;
      HI_STROBE: if (last_cycle) state_next = HI_HOLD;
      HI_HOLD:   if (last_cycle) state_next = HI_GAP;
      HI_GAP:    if (last_cycle) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase

    // Reload the counter on every state entry, otherwise count down.
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = state_len(state_next);
    end else if (cnt_reg != 4'd0) begin
      cnt_next = cnt_reg - 4'd1;
    end

    // Only the upper nibble needs keeping: the lower ten bits go straight
    // onto the bus at acceptance and data is held in its own output flop.
    hi_nib_next = accept ? bus.req_addr[13:10] : hi_nib_reg;
  end

  // Output logic: next values of the registered outputs, decoded from the
  // state being entered so the flops line up with the state register.
  always_comb begin
    ncs_next   = 1'b1;
    nwe_next   = 1'b1;
    addr_next  = addr_reg;
    data_next  = data_reg;
    ready_next = 1'b0;
    busy_next  = 1'b1;
    done_next  = 1'b0;

    case (state_next)
      LO_SETUP, LO_HOLD, HI_SETUP, HI_HOLD: ncs_next = 1'b0;
      LO_STROBE, HI_STROBE: begin
        ncs_next = 1'b0;
        nwe_next = 1'b0;
      end
      IDLE: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
      default: ;
    endcase

    // Address and data move only on entry to a SETUP state, never while the
    // strobe is low, so the receiver always samples a stable bus.
    if (state_reg == IDLE && state_next == LO_SETUP) begin
      addr_next = {3'b000, bus.req_addr[9:0]};
      data_next = {7'b0, bus.req_data};
    end else if (state_reg == LO_GAP && state_next == HI_SETUP) begin
      addr_next = {2'b00, 1'b1, 6'b0, hi_nib_reg};
    end

    // Completion pulse in the first IDLE cycle after the second phase.
    if (state_reg == HI_GAP && state_next == IDLE) begin
      done_next = 1'b1;
    end
  end

  // Output registers; reset releases the bus at once (ncs and nwe together).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_reg   <= 1'b1;
      nwe_reg   <= 1'b1;
      addr_reg  <= 13'd0;
      data_reg  <= 8'd0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      ncs_reg   <= ncs_next;
      nwe_reg   <= nwe_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.ncs       = ncs_reg;
  assign bus.nwe       = nwe_reg;
  assign bus.nwe1      = 1'b1;
  assign bus.addr_pr   = addr_reg;
  assign bus.sram_data = data_reg;
  assign bus.req_ready = ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_vga_bus_writer.sv
// Randomised bench for vga_bus_writer. Two instances: defaults (dut 0) and
// SETUP=2/STROBE=3/HOLD=2/GAP=3 (dut 1). A per-cycle reference computes the
// expected bus from the offset since acceptance; a bus receiver decodes the
// two phases into a framebuffer that is compared with a reference one.
module tb_vga_bus_writer;

  localparam int B_SETUP  = 2;
  localparam int B_STROBE = 3;
  localparam int B_HOLD   = 2;
  localparam int B_GAP    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_bus_writer_if a_if ();
  vga_bus_writer_if b_if ();

  vga_bus_writer u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  vga_bus_writer #(
    .SETUP  (B_SETUP),
    .STROBE (B_STROBE),
    .HOLD   (B_HOLD),
    .GAP    (B_GAP)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // Request drive, per instance
  logic        vld [2];
  logic [13:0] adr [2];
  logic        dat [2];

  assign a_if.req_valid = vld[0];
  assign a_if.req_addr  = adr[0];
  assign a_if.req_data  = dat[0];
  assign b_if.req_valid = vld[1];
  assign b_if.req_addr  = adr[1];
  assign b_if.req_data  = dat[1];

  // Observed outputs: {ncs, nwe, nwe1, addr[12:0], data[7:0], ready, busy, done}
  logic [26:0] obs [2];
  assign obs[0] = {a_if.ncs, a_if.nwe, a_if.nwe1, a_if.addr_pr, a_if.sram_data,
                   a_if.req_ready, a_if.busy, a_if.done};
  assign obs[1] = {b_if.ncs, b_if.nwe, b_if.nwe1, b_if.addr_pr, b_if.sram_data,
                   b_if.req_ready, b_if.busy, b_if.done};

  int p_setup  [2] = '{1, B_SETUP};
  int p_strobe [2] = '{2, B_STROBE};
  int p_hold   [2] = '{1, B_HOLD};
  int p_gap    [2] = '{1, B_GAP};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int per(input int d);
    return p_setup[d] + p_strobe[d] + p_hold[d] + p_gap[d];
  endfunction

  // Reference state: offset since acceptance (-1 when idle), last bus values
  int          off       [2] = '{-1, -1};
  logic [12:0] last_addr [2] = '{13'd0, 13'd0};
  logic        last_data [2] = '{1'b0, 1'b0};
  logic [13:0] cap_addr  [2];
  int          n_acc     [2] = '{0, 0};
  int          n_cmp     [2] = '{0, 0};
  int          n_done    [2] = '{0, 0};
  bit          ref_fb    [2][16384];
  bit          rx_fb     [2][16384];
  logic        prev_nwe  [2] = '{1'b1, 1'b1};
  logic [9:0]  rx_lo     [2] = '{10'd0, 10'd0};

  // Expected outputs from the offset: within each phase of P cycles, ncs is
  // low for the first SETUP+STROBE+HOLD cycles and nwe low for the STROBE
  // cycles after SETUP; offset 2P is the done cycle.
  function automatic logic [26:0] expect_bus(input int d);
    int   p;
    int   r;
    logic ncs_e, nwe_e, rdy_e, dn_e;
    p     = per(d);
    ncs_e = 1'b1;
    nwe_e = 1'b1;
    rdy_e = 1'b1;
    dn_e  = 1'b0;
    if (off[d] >= 0 && off[d] < 2 * p) begin
      r     = off[d] % p;
      ncs_e = !(r < p_setup[d] + p_strobe[d] + p_hold[d]);
      nwe_e = !(r >= p_setup[d] && r < p_setup[d] + p_strobe[d]);
      rdy_e = 1'b0;
    end else if (off[d] == 2 * p) begin
      dn_e = 1'b1;
    end
    return {ncs_e, nwe_e, 1'b1, last_addr[d], 7'b0, last_data[d], rdy_e, ~rdy_e, dn_e};
  endfunction

  // Reference model update on each edge
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        off[d]       = -1;
        last_addr[d] = 13'd0;
        last_data[d] = 1'b0;
      end else if ((off[d] < 0 || off[d] == 2 * per(d)) && vld[d]) begin
        off[d]       = 0;
        cap_addr[d]  = adr[d];
        last_data[d] = dat[d];
        last_addr[d] = {3'b000, adr[d][9:0]};
        n_acc[d]++;
      end else if (off[d] >= 0) begin
        off[d]++;
        if (off[d] == per(d))
          last_addr[d] = {2'b00, 1'b1, 6'b0, cap_addr[d][13:10]};
        if (off[d] == 2 * per(d)) begin
          ref_fb[d][cap_addr[d]] = last_data[d];
          n_cmp[d]++;
          $display("txn dut%0d addr=%04h data=%0d t=%0t", d, cap_addr[d], last_data[d], $time);
        end else if (off[d] > 2 * per(d)) begin
          off[d] = -1;
        end
      end
    end
  end

  // Per-cycle comparison and bus receiver (samples away from the posedge)
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bus%0d", d), 32'(obs[d]), 32'(expect_bus(d)));
      if (obs[d][0]) n_done[d]++;
      if (prev_nwe[d] == 1'b0 && obs[d][25] && !obs[d][26]) begin
        if (!obs[d][21]) rx_lo[d] = obs[d][20:11];
        else             rx_fb[d][{obs[d][14:11], rx_lo[d]}] = obs[d][3];
      end
      prev_nwe[d] = obs[d][25];
    end
  end

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (off[d] >= 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic write_pixel(input int d, input logic [13:0] a, input logic v);
    wait_idle(d);
    vld[d] = 1'b1;
    adr[d] = a;
    dat[d] = v;
    @(posedge clk);
    @(negedge clk);
    vld[d] = 1'b0;
    wait_idle(d);
  endtask

  // Single write with waveform measurements against fixed expectations
  task automatic directed(input int d, input logic [13:0] a, input logic v,
                          input logic [12:0] exp_lo, input logic [12:0] exp_hi,
                          input int exp_strobe, input int exp_gap, input int exp_done_k);
    int p, lo_n, hi_n, gap_n, done_k;
    logic [12:0] lo_a, hi_a;
    logic [7:0]  data_a;
    p = per(d);
    lo_n = 0; hi_n = 0; gap_n = 0; done_k = -1;
    lo_a = '0; hi_a = '0; data_a = '0;
    wait_idle(d);
    vld[d] = 1'b1;
    adr[d] = a;
    dat[d] = v;
    @(posedge clk);
    @(negedge clk);
    vld[d] = 1'b0;
    for (int k = 0; k <= 2 * p + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        lo_a   = obs[d][23:11];
        data_a = obs[d][10:3];
      end
      if (k == p) hi_a = obs[d][23:11];
      if (!obs[d][25]) begin
        if (k < p) lo_n++;
        else       hi_n++;
      end
      if (k < p && obs[d][26]) gap_n++;
      if (obs[d][0] && done_k < 0) done_k = k;
    end
    chk($sformatf("dir%0d_lo_addr", d), 32'(lo_a), 32'(exp_lo));
    chk($sformatf("dir%0d_hi_addr", d), 32'(hi_a), 32'(exp_hi));
    chk($sformatf("dir%0d_data", d), 32'(data_a), 32'(v));
    chk($sformatf("dir%0d_lo_strobe", d), 32'(lo_n), 32'(exp_strobe));
    chk($sformatf("dir%0d_hi_strobe", d), 32'(hi_n), 32'(exp_strobe));
    chk($sformatf("dir%0d_gap", d), 32'(gap_n), 32'(exp_gap));
    chk($sformatf("dir%0d_done_k", d), 32'(done_k), 32'(exp_done_k));
  endtask

  logic [13:0] fb_addr [4] = '{14'd0, 14'd1023, 14'd1024, 14'd16383};

  initial begin
    int base, n, mism;
    vld = '{1'b0, 1'b0};
    adr = '{14'd0, 14'd0};
    dat = '{1'b0, 1'b0};
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_state0", 32'(obs[0]), 32'h7000004);
    chk("rst_state1", 32'(obs[1]), 32'h7000004);
    @(negedge clk);
    rst = 1'b0;

    // Single writes: defaults and the slower timing set
    directed(0, 14'h2A5F, 1'b1, 13'h025F, 13'h040A, 2, 1, 10);
    directed(1, 14'h3FFF, 1'b1, 13'h03FF, 13'h040F, 3, 3, 20);

    // Boundary addresses through the bus receiver: all ones, then alternating
    for (int i = 0; i < 4; i++) write_pixel(0, fb_addr[i], 1'b1);
    for (int i = 0; i < 4; i++) write_pixel(0, fb_addr[i], (i % 2) == 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fb_%0d", fb_addr[i]), 32'(rx_fb[0][fb_addr[i]]), 32'((i % 2) == 0));

    // Request pulsed while busy is ignored
    wait_idle(0);
    base = n_done[0];
    vld[0] = 1'b1; adr[0] = 14'h0ABC; dat[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    vld[0] = 1'b1; adr[0] = 14'h1234; dat[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("busy_ready", 32'(obs[0][2]), 32'd0);
    wait_idle(0);
    chk("busy_one_done", 32'(n_done[0] - base), 32'd1);
    chk("busy_ignored_px", 32'(rx_fb[0][14'h1234]), 32'd0);
    chk("busy_first_px", 32'(rx_fb[0][14'h0ABC]), 32'd1);

    // Back-to-back: valid held high, fresh address every cycle
    base = n_done[0];
    n = n_acc[0];
    vld[0] = 1'b1;
    for (int c = 0; c < 3000 && (n_acc[0] - n) < 100; c++) begin
      adr[0] = 14'($urandom_range(0, 16383));
      dat[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    vld[0] = 1'b0;
    wait_idle(0);
    chk("b2b_done", 32'(n_done[0] - base), 32'd100);

    // Sparse random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        vld[d] = ($urandom_range(0, 3) == 0);
        adr[d] = 14'($urandom_range(0, 16383));
        dat[d] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    vld = '{1'b0, 1'b0};
    wait_idle(0);
    wait_idle(1);

    // Reset during HI_STROBE drops the write and releases the bus at once
    vld[0] = 1'b1; adr[0] = 14'h1555; dat[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    n = 0;
    while (off[0] != per(0) + p_setup[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_nwe", 32'(obs[0][25]), 32'd0);
    base = n_done[0];
    #2 rst = 1'b1;
    #1;
    chk("rst_ncs", 32'(obs[0][26]), 32'd1);
    chk("rst_nwe", 32'(obs[0][25]), 32'd1);
    chk("rst_nwe1", 32'(obs[0][24]), 32'd1);
    chk("rst_addr", 32'(obs[0][23:11]), 32'd0);
    chk("rst_done", 32'(obs[0][0]), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    chk("rst_dropped_px", 32'(rx_fb[0][14'h1555]), 32'(ref_fb[0][14'h1555]));
    write_pixel(0, 14'h2001, 1'b1);
    chk("post_rst_done", 32'(n_done[0] - base), 32'd1);
    chk("post_rst_px", 32'(rx_fb[0][14'h2001]), 32'd1);

    // Whole-framebuffer and completion-count agreement
    for (int d = 0; d < 2; d++) begin
      mism = 0;
      for (int i = 0; i < 16384; i++)
        if (rx_fb[d][i] != ref_fb[d][i]) mism++;
      chk($sformatf("fb_all%0d", d), 32'(mism), 32'd0);
      chk($sformatf("done_count%0d", d), 32'(n_done[d]), 32'(n_cmp[d]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
